fifo_frame_reader: RTL and testbench

Downstream consumer of the 256x32 synchronous FIFO (`sync_fifo_256x32b`) in the all-IO test datapath. The block drains the FIFO through its standard read port, which has 1-cycle read latency and an unregistered output. It re-times the words into a valid/ready stream through a 2-entry output buffer, groups every FRAME_LEN words into a frame, and appends an XOR checksum beat flagged with `m_last`. It provides full backpressure: no word read from the FIFO is ever dropped or duplicated.

---
 rtl/fifo_frame_reader_if.sv | 23 ++
 rtl/fifo_frame_reader.sv | 143 ++++++++++++++
 tb/tb_fifo_frame_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_frame_reader_if.sv
// Stream and FIFO read-port bundle for fifo_frame_reader.
// The design side is "master"; the FIFO model and sink side is "slave".
interface fifo_frame_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    input  fifo_rd_data, fifo_rd_empty, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_rd_data, fifo_rd_empty, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fifo_frame_reader.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream, grouping
// FRAME_LEN words per frame and closing each frame with an XOR checksum beat.
module fifo_frame_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 16,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  fifo_frame_reader_if.master   bus,
  output logic [FCNT_WIDTH-1:0] frame_cnt,
  output logic                  busy
);

  localparam int IW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, READ, WAIT_DATA, CSUM} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         issued;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] csum;
  logic [DATA_WIDTH-1:0] d0, d1;
  logic                  l0, l1;
  logic [1:0]            occ;

  logic                  pop, room, rd_en, csum_push, frame_start, push, push_last;
  logic [DATA_WIDTH-1:0] push_data;

  assign pop  = (occ != 2'd0) && bus.m_ready;
  // occ + inflight - pop < 2, rearranged to stay unsigned
  assign room = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

  assign rd_en     = (state == READ) && (issued < IW'(FRAME_LEN)) && !bus.fifo_rd_empty && room;
  assign csum_push = (state == CSUM) && ((occ != 2'd2) || pop);

  // Checksum and captured data never compete: no read is in flight during CSUM.
  assign push      = inflight || csum_push;
  assign push_data = inflight ? bus.fifo_rd_data : csum;
  assign push_last = !inflight;

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt   = READ;
          frame_start = 1'b1;
        end
      end
      READ: begin
        if (rd_en && (issued == IW'(FRAME_LEN - 1))) state_nxt = WAIT_DATA;
      end
      // The final read lands at the end of this cycle, so csum is final for CSUM.
      WAIT_DATA: state_nxt = CSUM;
      CSUM: begin
        if (csum_push) begin
          if (en) begin
            state_nxt   = READ;
            frame_start = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issued    <= '0;
      inflight  <= 1'b0;
      csum      <= '0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_en;
      busy     <= (state_nxt != IDLE);
      if (frame_start)  issued <= '0;
      else if (rd_en)   issued <= issued + IW'(1);
      if (frame_start)  csum <= '0;
      else if (inflight) csum <= csum ^ bus.fifo_rd_data;
      if (pop && l0) frame_cnt <= frame_cnt + FCNT_WIDTH'(1);
    end
  end

  // Two-entry output buffer; d0/l0 is always the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0  <= '0;
      d1  <= '0;
      l0  <= 1'b0;
      l1  <= 1'b0;
      occ <= 2'd0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) begin
            d0  <= push_data;
            l0  <= push_last;
            occ <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            d0 <= push_data;
            l0 <= push_last;
          end else if (push) begin
            d1  <= push_data;
            l1  <= push_last;
            occ <= 2'd2;
          end else if (pop) begin
            occ <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            d0 <= d1;
            l0 <= l1;
            if (push) begin
              d1 <= push_data;
              l1 <= push_last;
            end else begin
              occ <= 2'd1;
            end
          end
        end
        default: occ <= 2'd0;
      endcase
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_data     = d0;
  assign bus.m_last     = l0;
  assign bus.m_valid    = (occ != 2'd0);

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: FIFO model + frame reference model, table-driven
// frames, hand-written corner sequences and a randomized run.
module tb_fifo_frame_reader;

  logic        clk;
  logic        rst_n;
  logic        en0, en1;
  logic [15:0] fcnt0, fcnt1;
  logic        busy0, busy1;

  fifo_frame_reader_if #(.DATA_WIDTH(32)) bus0 ();
  fifo_frame_reader_if #(.DATA_WIDTH(32)) bus1 ();

  fifo_frame_reader #(.DATA_WIDTH(32), .FRAME_LEN(16), .FCNT_WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .en(en0), .bus(bus0), .frame_cnt(fcnt0), .busy(busy0)
  );

  fifo_frame_reader #(.DATA_WIDTH(32), .FRAME_LEN(1), .FCNT_WIDTH(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .bus(bus1), .frame_cnt(fcnt1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO models: 1-cycle read latency, pointers only moved by their owners
  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:15];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;

  always @(posedge clk) begin
    if (bus0.fifo_rd_en) begin
      bus0.fifo_rd_data <= mem0[rp0 % 1024];
      rp0 <= rp0 + 1;
    end
    if (bus1.fifo_rd_en) begin
      bus1.fifo_rd_data <= mem1[rp1 % 16];
      rp1 <= rp1 + 1;
    end
  end
  assign bus0.fifo_rd_empty = (rp0 == wp0);
  assign bus1.fifo_rd_empty = (rp1 == wp1);

  int rmode0 = 0;
  always @(posedge clk) begin
    #1;
    case (rmode0)
      0:       bus0.m_ready = 1'b1;
      1:       bus0.m_ready = (bus0.m_ready === 1'b1) ? 1'b0 : 1'b1;
      default: bus0.m_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Sink monitors; beats are recorded mid-cycle and accepted on the next edge
  logic [31:0] got_d0[$], got_d1[$];
  logic        got_l0[$], got_l1[$];
  int          rden0 = 0, stab_viol = 0, ahead_viol = 0, outstanding = 0;
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv          <= 1'b0;
      outstanding <= 0;
    end else begin
      if (pv && !pr && (bus0.m_valid !== 1'b1 || bus0.m_data !== pd || bus0.m_last !== pl))
        stab_viol <= stab_viol + 1;
      if (outstanding > 2) ahead_viol <= ahead_viol + 1;
      if (bus0.fifo_rd_en) rden0 <= rden0 + 1;
      outstanding <= outstanding + (bus0.fifo_rd_en ? 1 : 0)
                     - ((bus0.m_valid && bus0.m_ready && !bus0.m_last) ? 1 : 0);
      if (bus0.m_valid && bus0.m_ready) begin
        got_d0.push_back(bus0.m_data);
        got_l0.push_back(bus0.m_last);
      end
      pv <= bus0.m_valid;
      pr <= bus0.m_ready;
      pd <= bus0.m_data;
      pl <= bus0.m_last;
      if (bus1.m_valid && bus1.m_ready) begin
        got_d1.push_back(bus1.m_data);
        got_l1.push_back(bus1.m_last);
      end
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push0(input logic [31:0] w);
    mem0[wp0 % 1024] = w;
    wp0++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en0   = 1'b0;
    en1   = 1'b0;
    #1;
    wp0 = rp0;
    wp1 = rp1;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_beats0(input int target, input int budget);
    int c = 0;
    while (got_d0.size() < target && c < budget) begin
      cyc(1);
      c++;
    end
    chk("beat_timeout", (got_d0.size() >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Reference: every fl words become fl data beats plus their XOR with last=1
  logic [31:0] exp_d[$];
  logic        exp_l[$];

  task automatic build_expect(input logic [31:0] w[$], input int fl);
    logic [31:0] acc = '0;
    exp_d.delete();
    exp_l.delete();
    for (int i = 0; i < w.size(); i++) begin
      exp_d.push_back(w[i]);
      exp_l.push_back(1'b0);
      acc ^= w[i];
      if ((i + 1) % fl == 0) begin
        exp_d.push_back(acc);
        exp_l.push_back(1'b1);
        acc = '0;
      end
    end
  endtask

  task automatic check_beats(input int base);
    chk("beat_count", got_d0.size() - base, exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      if (base + i < got_d0.size()) begin
        chk($sformatf("beat_data[%0d]", i), got_d0[base + i], exp_d[i]);
        chk($sformatf("beat_last[%0d]", i), {31'd0, got_l0[base + i]}, {31'd0, exp_l[i]});
      end
    end
  endtask

  typedef struct {
    int          nwords;
    logic [31:0] first;
    logic [31:0] step;
    int          rmode;
    logic [31:0] exp_csum;
    int          exp_frames;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] words[$];
  int          base, r0;

  initial begin
    vecs[0] = '{16, 32'h0000_0001, 32'h0000_0001, 0, 32'h0000_0010, 1};
    vecs[1] = '{32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0000, 2};
    vecs[2] = '{16, 32'h0000_1000, 32'h0000_1000, 2, 32'h0001_0000, 1};
    vecs[3] = '{16, 32'hDEAD_BEEF, 32'h0000_0000, 0, 32'h0000_0000, 1};

    rst_n       = 1'b1;
    en0         = 1'b0;
    en1         = 1'b0;
    bus1.m_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, bus0.m_valid}, 32'd0);
    chk("rst_data", bus0.m_data, 32'd0);
    chk("rst_last", {31'd0, bus0.m_last}, 32'd0);
    chk("rst_rden", {31'd0, bus0.fifo_rd_en}, 32'd0);
    chk("rst_fcnt", {16'd0, fcnt0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_busy_fl1", {31'd0, busy1}, 32'd0);
    cyc(2);
    rst_n = 1'b1;

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      do_reset();
      rmode0 = vecs[v].rmode;
      words.delete();
      for (int i = 0; i < vecs[v].nwords; i++) begin
        words.push_back(vecs[v].first + i * vecs[v].step);
        push0(vecs[v].first + i * vecs[v].step);
      end
      build_expect(words, 16);
      base = got_d0.size();
      r0   = rden0;
      en0  = 1'b1;
      wait_beats0(base + exp_d.size(), 3000);
      en0 = 1'b0;
      cyc(3);
      check_beats(base);
      for (int f = 0; f < vecs[v].exp_frames; f++)
        if (base + 16 + f * 17 < got_d0.size())
          chk($sformatf("vec%0d_csum%0d", v, f), got_d0[base + 16 + f * 17], vecs[v].exp_csum);
      chk($sformatf("vec%0d_rden", v), rden0 - r0, vecs[v].nwords);
      chk($sformatf("vec%0d_fcnt", v), {16'd0, fcnt0}, vecs[v].exp_frames);
    end
    rmode0 = 0;

    // FIFO empty mid-frame
    do_reset();
    words.delete();
    for (int i = 1; i <= 16; i++) words.push_back(i);
    build_expect(words, 16);
    base = got_d0.size();
    for (int i = 0; i < 8; i++) push0(words[i]);
    en0 = 1'b1;
    cyc(12);
    chk("gap_beats", got_d0.size() - base, 32'd8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("gap_valid", {31'd0, bus0.m_valid}, 32'd0);
    end
    cyc(1);
    for (int i = 8; i < 16; i++) push0(words[i]);
    wait_beats0(base + 17, 500);
    en0 = 1'b0;
    cyc(3);
    check_beats(base);
    if (base + 16 < got_d0.size()) chk("gap_csum", got_d0[base + 16], 32'h0000_0010);

    // en dropped three cycles into the frame
    do_reset();
    words.delete();
    for (int i = 0; i < 40; i++) begin
      words.push_back(i * 3 + 7);
      push0(i * 3 + 7);
    end
    words = words[0:15];
    build_expect(words, 16);
    base = got_d0.size();
    r0   = rden0;
    en0  = 1'b1;
    @(negedge clk);
    chk("start_rden_idle", {31'd0, bus0.fifo_rd_en}, 32'd0);
    @(negedge clk);
    chk("start_rden_first", {31'd0, bus0.fifo_rd_en}, 32'd1);
    cyc(2);
    en0 = 1'b0;
    wait_beats0(base + 17, 500);
    cyc(10);
    check_beats(base);
    chk("endrop_rden", rden0 - r0, 32'd16);
    chk("endrop_busy", {31'd0, busy0}, 32'd0);
    chk("endrop_fcnt", {16'd0, fcnt0}, 32'd1);

    // Reset mid-frame
    do_reset();
    for (int i = 0; i < 16; i++) push0(32'h50 + i);
    base = got_d0.size();
    en0  = 1'b1;
    wait_beats0(base + 5, 200);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus0.m_valid}, 32'd0);
    chk("midrst_data", bus0.m_data, 32'd0);
    chk("midrst_last", {31'd0, bus0.m_last}, 32'd0);
    chk("midrst_rden", {31'd0, bus0.fifo_rd_en}, 32'd0);
    chk("midrst_busy", {31'd0, busy0}, 32'd0);
    wp0 = rp0;
    cyc(2);
    rst_n = 1'b1;
    words.delete();
    for (int i = 0; i < 16; i++) begin
      words.push_back($urandom);
      push0(words[i]);
    end
    build_expect(words, 16);
    base = got_d0.size();
    wait_beats0(base + 17, 500);
    en0 = 1'b0;
    cyc(3);
    check_beats(base);
    chk("midrst_fcnt", {16'd0, fcnt0}, 32'd1);

    // Randomized supply and backpressure
    do_reset();
    rmode0 = 2;
    words.delete();
    base = got_d0.size();
    en0  = 1'b1;
    for (int c = 0; c < 4000 && got_d0.size() < base + 51; c++) begin
      if (words.size() < 48 && $urandom_range(0, 2) != 0) begin
        words.push_back($urandom);
        push0(words[words.size() - 1]);
      end
      cyc(1);
    end
    build_expect(words, 16);
    chk("rand_timeout", (got_d0.size() >= base + 51) ? 32'd1 : 32'd0, 32'd1);
    en0 = 1'b0;
    cyc(3);
    check_beats(base);
    chk("rand_fcnt", {16'd0, fcnt0}, 32'd3);
    rmode0 = 0;

    // FRAME_LEN = 1
    do_reset();
    mem1[wp1 % 16] = 32'hA5A5_A5A5;
    wp1++;
    mem1[wp1 % 16] = 32'h0000_FFFF;
    wp1++;
    base = got_d1.size();
    en1  = 1'b1;
    for (int c = 0; c < 200 && got_d1.size() < base + 4; c++) cyc(1);
    en1 = 1'b0;
    cyc(3);
    chk("fl1_count", got_d1.size() - base, 32'd4);
    if (got_d1.size() >= base + 4) begin
      chk("fl1_d0", got_d1[base],     32'hA5A5_A5A5);
      chk("fl1_l0", {31'd0, got_l1[base]},     32'd0);
      chk("fl1_d1", got_d1[base + 1], 32'hA5A5_A5A5);
      chk("fl1_l1", {31'd0, got_l1[base + 1]}, 32'd1);
      chk("fl1_d2", got_d1[base + 2], 32'h0000_FFFF);
      chk("fl1_l2", {31'd0, got_l1[base + 2]}, 32'd0);
      chk("fl1_d3", got_d1[base + 3], 32'h0000_FFFF);
      chk("fl1_l3", {31'd0, got_l1[base + 3]}, 32'd1);
    end
    chk("fl1_fcnt", {16'd0, fcnt1}, 32'd2);

    chk("stall_stability_violations", stab_viol, 32'd0);
    chk("read_ahead_violations", ahead_viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
